// File: rtl/reset_sequencer.sv
// reset_sequencer: releases N_STAGES active-low resets in order, each after its own delay and the previous stage's ack.
// All outputs registered; no backpressure. RSTSEQ_RETRY_EN enables re-releasing a timed-out stage up to MAX_RETRY times.
module reset_sequencer #(
  parameter int                        N_STAGES  = 5,
  parameter int                        CNT_W     = 26,
  parameter logic [N_STAGES*CNT_W-1:0] STAGE_DLY = {N_STAGES{CNT_W'(2097152)}},
  parameter logic [CNT_W-1:0]          TIMEOUT   = CNT_W'(33554431)
`ifdef RSTSEQ_RETRY_EN
  ,
  parameter int                        MAX_RETRY = 2
`endif
) (
  input  logic                iCLK,
  input  logic                iRST,
  input  logic                iSOFT_RST,
  input  logic [N_STAGES-1:0] iACK,
  output logic [N_STAGES-1:0] oRST,
  output logic [2:0]          oSTAGE,
  output logic                oDONE,
  output logic                oERR
);

  typedef enum logic [2:0] {S_HOLD, S_DELAY, S_WAIT, S_DONE, S_ERR} state_t;

  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [2:0]       LAST_K = 3'(N_STAGES - 1);

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [2:0]          r_k;
  logic [N_STAGES-1:0] r_rst;
  logic                r_done;
  logic                r_err;

  logic [CNT_W-1:0]    w_dly [8];
  logic [7:0]          w_ack;
  logic [N_STAGES-1:0] w_sel;
  logic [CNT_W-1:0]    w_dly_last;
  logic [CNT_W-1:0]    w_cnt_inc;
  logic                w_dly_hit;
  logic                w_tmo;

`ifdef RSTSEQ_RETRY_EN
  localparam int R_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  logic [R_W-1:0] r_retry;
`endif

  // Pad per-stage tables to 8 entries so the 3-bit stage index never selects out of range
  for (genvar g = 0; g < 8; g++) begin : g_pad
    if (g < N_STAGES) begin : g_on
      assign w_dly[g] = STAGE_DLY[g*CNT_W +: CNT_W];
      assign w_ack[g] = iACK[g];
    end else begin : g_off
      assign w_dly[g] = '0;
      assign w_ack[g] = 1'b0;
    end
  end

  for (genvar g = 0; g < N_STAGES; g++) begin : g_sel
    assign w_sel[g] = (r_k == 3'(g));
  end

  // A programmed delay of zero behaves like a one-cycle delay
  assign w_dly_last = (w_dly[r_k] == '0) ? '0 : (w_dly[r_k] - ONE);
  assign w_dly_hit  = (r_cnt == w_dly_last);
  assign w_tmo      = (TIMEOUT != '0) && (r_cnt == (TIMEOUT - ONE));
  assign w_cnt_inc  = (r_cnt == '1) ? r_cnt : (r_cnt + ONE);

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_state <= S_HOLD;
      r_cnt   <= '0;
      r_k     <= '0;
      r_rst   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
`ifdef RSTSEQ_RETRY_EN
      r_retry <= '0;
`endif
    end else if (iSOFT_RST) begin
      r_state <= S_HOLD;
      r_cnt   <= '0;
      r_k     <= '0;
      r_rst   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
`ifdef RSTSEQ_RETRY_EN
      r_retry <= '0;
`endif
    end else begin
      case (r_state)
        S_HOLD: begin
          r_state <= S_DELAY;
          r_cnt   <= '0;
        end
        S_DELAY: begin
          if (w_dly_hit) begin
            r_rst   <= r_rst | w_sel;
            r_cnt   <= '0;
            r_state <= S_WAIT;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_WAIT: begin
          if (w_ack[r_k]) begin
            if (r_k == LAST_K) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_k     <= r_k + 3'd1;
              r_cnt   <= '0;
              r_state <= S_DELAY;
`ifdef RSTSEQ_RETRY_EN
              r_retry <= '0;
`endif
            end
          end else if (w_tmo) begin
`ifdef RSTSEQ_RETRY_EN
            if (r_retry < R_W'(MAX_RETRY)) begin
              r_retry <= r_retry + 1'b1;
              r_rst   <= r_rst & ~w_sel;
              r_cnt   <= '0;
              r_state <= S_DELAY;
            end else begin
              r_err   <= 1'b1;
              r_rst   <= '0;
              r_done  <= 1'b0;
              r_state <= S_ERR;
            end
`else
            r_err   <= 1'b1;
            r_rst   <= '0;
            r_done  <= 1'b0;
            r_state <= S_ERR;
`endif
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_DONE, S_ERR: begin
          r_state <= r_state;
        end
        default: begin
          r_state <= S_HOLD;
        end
      endcase
    end
  end

  assign oRST   = r_rst;
  assign oSTAGE = r_k;
  assign oDONE  = r_done;
  assign oERR   = r_err;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: stimulus queues each expected output change with its cycle; a monitor pops on every change.
// Build with RSTSEQ_RETRY_EN defined to add the retry scenarios.
module tb_reset_sequencer;

  logic       iCLK;
  logic       iRST;
  logic       iSOFT_RST;
  logic [2:0] iACK;
  logic [2:0] oRST;
  logic [2:0] oSTAGE;
  logic       oDONE;
  logic       oERR;

  reset_sequencer #(
    .N_STAGES (3),
    .CNT_W    (8),
    .STAGE_DLY({8'd2, 8'd8, 8'd4}),
    .TIMEOUT  (8'd16)
  ) dut (
    .iCLK     (iCLK),
    .iRST     (iRST),
    .iSOFT_RST(iSOFT_RST),
    .iACK     (iACK),
    .oRST     (oRST),
    .oSTAGE   (oSTAGE),
    .oDONE    (oDONE),
    .oERR     (oERR)
  );

  typedef struct {
    int         cyc;
    logic [7:0] val;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_err  = 0;

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;
  always @(posedge iCLK) cyc <= cyc + 1;

  function automatic logic [7:0] mk(input logic err, input logic done,
                                    input logic [2:0] stg, input logic [2:0] rst);
    return {err, done, stg, rst};
  endfunction

  task automatic push(input int c, input logic [7:0] v, input string t);
    exp_t e;
    e.cyc = c;
    e.val = v;
    e.tag = t;
    exp_q.push_back(e);
  endtask

  task automatic run_to(input int e);
    while (cyc < e) @(negedge iCLK);
  endtask

  task automatic chk_now(input string t, input logic [7:0] req);
    logic [7:0] got;
    got = {oERR, oDONE, oSTAGE, oRST};
    n_vec++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s: got %b required %b", t, got, req);
    end
  endtask

  // Output word is {err, done, stage[2:0], rst[2:0]}; any change must match the queue head
  initial begin : monitor
    logic [7:0] prev;
    logic [7:0] cur;
    exp_t       e;
    prev = '0;
    forever begin
      @(negedge iCLK);
      cur = {oERR, oDONE, oSTAGE, oRST};
      if (cur !== prev) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_change: got %b at cycle %0d, required no change", cur, cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.val !== cur) begin
            n_err++;
            $display("FAIL %s: got %b at cycle %0d, required %b at cycle %0d",
                     e.tag, cur, cyc, e.val, e.cyc);
          end
        end
        prev = cur;
      end
    end
  end

  // Stage timing with D={4,8,2} and acks sampled 3 cycles after each release
  task automatic stage01(input int b, output int r2);
    int r0;
    int r1;
    r0 = b + 4;
    r1 = r0 + 3 + 8;
    r2 = r1 + 3 + 2;
    push(r0,     mk(0, 0, 3'd0, 3'b001), "rel0");
    push(r0 + 3, mk(0, 0, 3'd1, 3'b001), "ack0");
    push(r1,     mk(0, 0, 3'd1, 3'b011), "rel1");
    push(r1 + 3, mk(0, 0, 3'd2, 3'b011), "ack1");
    push(r2,     mk(0, 0, 3'd2, 3'b111), "rel2");
    run_to(r0 + 2); iACK[0] = 1'b1;
    run_to(r1 + 2); iACK[1] = 1'b1;
  endtask

  task automatic nominal_run(input int b);
    int r2;
    stage01(b, r2);
    push(r2 + 3, mk(0, 1, 3'd2, 3'b111), "done");
    run_to(r2 + 2); iACK[2] = 1'b1;
    run_to(r2 + 5); iACK = 3'b000;
    run_to(r2 + 9);
  endtask

  task automatic soft_pulse(output int b);
    int c;
    c = cyc;
    iSOFT_RST = 1'b1;
    iACK      = 3'b000;
    push(c + 1, 8'h00, "soft_clr");
    run_to(c + 3);
    iSOFT_RST = 1'b0;
    b = c + 4;
  endtask

  initial begin : watchdog
    #60000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int   b;
    int   r0;
    int   r1;
    exp_t e;
    iRST      = 1'b0;
    iSOFT_RST = 1'b0;
    iACK      = 3'b000;

    run_to(2);
    chk_now("reset_state", 8'h00);
    iRST = 1'b1;
    nominal_run(3);

    // Restart from DONE
    soft_pulse(b);
    nominal_run(b);

    // Restart from the middle of stage 1's delay
    soft_pulse(b);
    push(b + 4, mk(0, 0, 3'd0, 3'b001), "md_rel0");
    push(b + 7, mk(0, 0, 3'd1, 3'b001), "md_ack0");
    run_to(b + 6); iACK[0] = 1'b1;
    run_to(b + 9);
    soft_pulse(b);
    nominal_run(b);

    // Ack arriving on the last timeout cycle wins; stage 1 then times out
    soft_pulse(b);
    r0 = b + 4;
    r1 = r0 + 16 + 8;
    push(r0,      mk(0, 0, 3'd0, 3'b001), "tie_rel0");
    push(r0 + 16, mk(0, 0, 3'd1, 3'b001), "tie_ack0");
    push(r1,      mk(0, 0, 3'd1, 3'b011), "tmo_rel1");
    push(r1 + 16, mk(1, 0, 3'd1, 3'b000), "tmo_err");
    run_to(r0 + 15); iACK[0] = 1'b1;
    run_to(r1 + 22);

    // Leave ERROR by soft restart, then hit the async reset inside WAIT_ACK
    soft_pulse(b);
    push(b + 4,  mk(0, 0, 3'd0, 3'b001), "ar_rel0");
    push(b + 10, 8'h00, "ar_clr");
    run_to(b + 9);
    #2 iRST = 1'b0;
    #1 chk_now("async_rst", 8'h00);
    run_to(b + 12);
    iRST = 1'b1;
    nominal_run(b + 13);

`ifdef RSTSEQ_RETRY_EN
    begin
      int r2;
      soft_pulse(b);
      stage01(b, r2);
      push(r2 + 16, mk(0, 0, 3'd2, 3'b011), "rty_drop1");
      push(r2 + 18, mk(0, 0, 3'd2, 3'b111), "rty_rel1");
      push(r2 + 34, mk(0, 0, 3'd2, 3'b011), "rty_drop2");
      push(r2 + 36, mk(0, 0, 3'd2, 3'b111), "rty_rel2");
      push(r2 + 52, mk(1, 0, 3'd2, 3'b000), "rty_err");
      run_to(r2 + 56);

      soft_pulse(b);
      stage01(b, r2);
      push(r2 + 16, mk(0, 0, 3'd2, 3'b011), "rty2_drop1");
      push(r2 + 18, mk(0, 0, 3'd2, 3'b111), "rty2_rel1");
      push(r2 + 34, mk(0, 0, 3'd2, 3'b011), "rty2_drop2");
      push(r2 + 36, mk(0, 0, 3'd2, 3'b111), "rty2_rel2");
      push(r2 + 39, mk(0, 1, 3'd2, 3'b111), "rty2_done");
      run_to(r2 + 38); iACK[2] = 1'b1;
      run_to(r2 + 43);
    end
`endif

    run_to(cyc + 3);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL %s: got no change, required %b at cycle %0d", e.tag, e.val, e.cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
